// File: rtl/bit_serial_comparator.sv
// -----------------------------------------------------------------------------
// bit_serial_comparator
//
// Compares two unsigned WIDTH-bit operands one bit per clock, MSB first.
// A start request in IDLE captures both operands. The block then spends
// exactly WIDTH cycles in SHIFT and one cycle in DONE before returning to
// IDLE. The three result flags are registered on the SHIFT->DONE edge and
// hold their value until the next comparison completes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      comparison request; only sampled in IDLE
//   a_in       operand A, captured on the accepted start edge
//   b_in       operand B, captured on the accepted start edge
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse while the FSM is in DONE
//   eq_out     A == B
//   b_greater  B > A (unsigned)
//   a_greater  A > B (unsigned)
// -----------------------------------------------------------------------------
module bit_serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             eq_out,
  output logic             b_greater,
  output logic             a_greater
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               e_q, e_d;
  logic               g_q, g_d;
  logic               eq_q, eq_d;
  logic               bg_q, bg_d;
  logic               ag_q, ag_d;

  // One bit-compare slice on the current MSBs. Once e has dropped, g can
  // no longer change: the highest differing bit already decided the result.
  logic bit_a, bit_b, e_step, g_step;

  always_comb begin
    bit_a  = sa_q[WIDTH-1];
    bit_b  = sb_q[WIDTH-1];
    e_step = e_q & ~(bit_a ^ bit_b);
    g_step = g_q | (~bit_a & bit_b & e_q);
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    g_d     = g_q;
    eq_d    = eq_q;
    bg_d    = bg_q;
    ag_d    = ag_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a_in;
          sb_d    = b_in;
          cnt_d   = CNT_W'(WIDTH - 1);
          e_d     = 1'b1;
          g_d     = 1'b0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        e_d   = e_step;
        g_d   = g_step;
        sa_d  = {sa_q[WIDTH-2:0], 1'b0};
        sb_d  = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        // Last slice: publish the decision using the values computed from
        // this final bit rather than the stale e_q/g_q.
        if (cnt_q == '0) begin
          state_d = S_DONE;
          eq_d    = e_step;
          bg_d    = g_step;
          ag_d    = ~e_step & ~g_step;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      e_q     <= 1'b1;
      g_q     <= 1'b0;
      eq_q    <= 1'b0;
      bg_q    <= 1'b0;
      ag_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      g_q     <= g_d;
      eq_q    <= eq_d;
      bg_q    <= bg_d;
      ag_q    <= ag_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign eq_out    = eq_q;
  assign b_greater = bg_q;
  assign a_greater = ag_q;

endmodule

// File: tb/tb_bit_serial_comparator.sv
module tb_bit_serial_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         eq_out;
  logic         b_greater;
  logic         a_greater;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2:0] prev_res;

  bit_serial_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .eq_out    (eq_out),
    .b_greater (b_greater),
    .a_greater (a_greater)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned comparison, packed as {eq, b>a, a>b}.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    return {(a == b), (b > a), (a > b)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one comparison and follow it to completion. While busy, start and
  // the operand inputs are scrambled; they must have no effect.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noisy);
    int n;
    logic [2:0] exp;
    exp   = ref_cmp(a, b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();                      // accept edge
    start = 1'b0;
    check({tag, ".busy"}, busy, 1'b1);
    n = 0;
    while (n < 40) begin
      if (noisy) begin
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        start = 1'($urandom);
      end
      step();
      n++;
      if (done === 1'b1) break;
      check({tag, ".hold"}, {eq_out, b_greater, a_greater}, prev_res);
    end
    start = 1'b0;
    // Counting the accept edge as edge 1, done rises after edge WIDTH+1.
    check({tag, ".latency"}, n, W);
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".result"}, {eq_out, b_greater, a_greater}, exp);
    $display("op %s a=%02h b=%02h eq=%0b bg=%0b ag=%0b edges=%0d",
             tag, a, b, eq_out, b_greater, a_greater, n);
    step();
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".idle"}, busy, 1'b0);
    prev_res = exp;
  endtask

  initial begin
    int t1;
    int t2;
    int dcount;
    logic [W-1:0] ra, rb;

    rst   = 1'b1;
    start = 1'b1;                // reset must win over start
    a_in  = 8'h12;
    b_in  = 8'h34;
    step();
    step();
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.result", {eq_out, b_greater, a_greater}, 3'b000);
    rst   = 1'b0;
    start = 1'b0;
    prev_res = 3'b000;
    step();
    check("idle.busy", busy, 1'b0);

    // Directed cases
    run_op("equal", 8'h5A, 8'h5A, 1'b0);
    run_op("msb",   8'h80, 8'h7F, 1'b0);
    run_op("lsb",   8'h00, 8'h01, 1'b0);
    run_op("max0",  8'hFF, 8'h00, 1'b0);
    run_op("zero",  8'h00, 8'h00, 1'b0);

    // Ignored start during SHIFT with new operands
    a_in = 8'h10; b_in = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    t1 = 0;
    while (done !== 1'b1 && t1 < 40) begin step(); t1++; end
    check("ign.done", done, 1'b1);
    check("ign.result", {eq_out, b_greater, a_greater}, ref_cmp(8'h10, 8'h20));
    $display("op ignored_start a=10 b=20 eq=%0b bg=%0b ag=%0b", eq_out, b_greater, a_greater);
    dcount = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    check("ign.single_done", dcount, 0);
    check("ign.idle", busy, 1'b0);
    prev_res = ref_cmp(8'h10, 8'h20);

    // Reset in the middle of SHIFT
    a_in = 8'h01; b_in = 8'h02; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.busy", busy, 1'b0);
    check("abort.done", done, 1'b0);
    check("abort.result", {eq_out, b_greater, a_greater}, 3'b000);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    check("abort.no_done", dcount, 0);
    $display("op abort a=01 b=02 busy=%0b done_seen=%0d", busy, dcount);
    prev_res = 3'b000;
    run_op("after_abort", 8'hFF, 8'hFF, 1'b0);

    // Back-to-back with start held high
    a_in = 8'h03; b_in = 8'h03; start = 1'b1;
    step();
    t1 = 0;
    while (done !== 1'b1 && t1 < 40) begin step(); t1++; end
    check("b2b.done1", done, 1'b1);
    check("b2b.res1", {eq_out, b_greater, a_greater}, ref_cmp(8'h03, 8'h03));
    t1 = cyc;
    $display("op b2b1 a=03 b=03 eq=%0b bg=%0b ag=%0b cyc=%0d", eq_out, b_greater, a_greater, t1);
    step();                      // back in IDLE; next edge accepts
    a_in = 8'hF0; b_in = 8'h0F;
    step();
    a_in = 8'h55; b_in = 8'hAA;  // must not matter
    t2 = 0;
    while (done !== 1'b1 && t2 < 40) begin step(); t2++; end
    start = 1'b0;
    t2 = cyc;
    check("b2b.done2", done, 1'b1);
    check("b2b.spacing", t2 - t1, W + 2);
    check("b2b.res2", {eq_out, b_greater, a_greater}, ref_cmp(8'hF0, 8'h0F));
    $display("op b2b2 a=F0 b=0F eq=%0b bg=%0b ag=%0b cyc=%0d", eq_out, b_greater, a_greater, t2);
    step();
    step();
    prev_res = ref_cmp(8'hF0, 8'h0F);

    // Randomized comparisons with bus noise while busy
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      case (i % 4)
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(W - 1, 0));
        default: rb = W'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), ra, rb, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_comparator.md
BIT_SERIAL_COMPARATOR -- requirements
Module: bit_serial_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request a comparison; sampled only in IDLE.
REQ-005 Port: a_in  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 Port: b_in  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 Port: busy  output  1  high whenever the state is not IDLE.
REQ-008 Port: done  output  1  one-cycle pulse when a result becomes valid.
REQ-009 Port: eq_out  output  1  registered result: A == B.
REQ-010 Port: b_greater  output  1  registered result: B > A, unsigned.
REQ-011 Port: a_greater  output  1  registered result: A > B, unsigned.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 SHALL, at that edge, load a_in/b_in into shift registers sa/sb, set e=1, g=0, set bit counter to WIDTH-1, and go to SHIFT.
REQ-014 IDLE with start=0 SHALL hold all state and outputs.
REQ-015 Each SHIFT cycle SHALL process the MSBs sa[WIDTH-1], sb[WIDTH-1], MSB-first, as one bit-compare slice: e_next = e AND (a XNOR b); g_next = g OR (NOT a AND b AND e).
REQ-016 Each SHIFT cycle SHALL shift sa and sb left by one and decrement the counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, with no early exit, and then go to DONE.
REQ-018 On the SHIFT->DONE edge, the final e/g SHALL be registered into the result outputs: eq_out=e, b_greater=g, a_greater=NOT e AND NOT g.
REQ-019 DONE SHALL assert done for exactly one cycle and then go to IDLE unconditionally.
REQ-020 Latency: done SHALL be high in the cycle starting WIDTH+1 edges after the accepted start edge.
REQ-021 At most one of eq_out, b_greater, a_greater SHALL be 1; after the first completed comparison, exactly one SHALL be 1.
REQ-022 Result outputs SHALL hold their value until the next SHIFT->DONE edge; a new start SHALL NOT clear them.
REQ-023 start in SHIFT or DONE SHALL be ignored, neither queued nor restarting the comparison; a_in/b_in changes while busy SHALL have no effect.
REQ-024 A start that is asserted continuously SHALL be accepted again on the first IDLE cycle after DONE, giving back-to-back comparisons every WIDTH+2 cycles.
REQ-025 Once e=0, g SHALL NOT change for the remainder of the operation (decided by the highest differing bit).

Reset
REQ-026 rst=1 SHALL, at the next edge, force IDLE and clear sa, sb, counter and e/g, with e=1, g=0.
REQ-027 rst=1 SHALL, at the next edge, drive busy=0, done=0, eq_out=0, b_greater=0, a_greater=0.
REQ-028 rst SHALL take priority over start and over every FSM transition.
REQ-029 rst asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse and no result update SHALL follow.

Verification (WIDTH=8)
REQ-030 Equal operands: A=0x5A, B=0x5A, start pulse -> done 9 cycles later; eq_out=1, b_greater=0, a_greater=0.
REQ-031 MSB decides: A=0x80, B=0x7F -> a_greater=1. Then A=0x00, B=0x01 (LSB decides) -> b_greater=1, eq_out=0.
REQ-032 Ignored start: start pulse with A=0x10, B=0x20; at cycle 3 of SHIFT, pulse start with A=0xFF, B=0x00 -> single done; b_greater=1.
REQ-033 Reset mid-operation: start with A=0x01, B=0x02; rst in cycle 4 of SHIFT -> busy=0 next cycle, no done, all results 0; a subsequent A=0xFF, B=0xFF start -> eq_out=1.
REQ-034 Back-to-back: start held high across operand pairs (0x03,0x03), (0xF0,0x0F) -> done pulses 10 cycles apart; results eq_out=1, then a_greater=1.
